// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: serve/play/point/game-over sequencing and scoring for two-player pong.
// Optional feature macro PONG_SPEEDUP_EN: ball speed steps up with paddle hits.
`timescale 1ns/1ps
module pong_game_ctrl #(
  parameter int WIN_SCORE     = 7,
  parameter int SERVE_FRAMES  = 60,
  parameter int POINT_FRAMES  = 90,
  parameter int HITS_PER_STEP = 4
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       p1_start,
  input  logic       p2_start,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       paddle_hit,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner,
  output logic [2:0] state,
  output logic [2:0] ball_speed,
  output logic [7:0] led
);

  localparam int FMAX = (SERVE_FRAMES > POINT_FRAMES) ?
                        SERVE_FRAMES : POINT_FRAMES;
  localparam int FW = $clog2(FMAX + 1);
  localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES - 1);
  localparam logic [FW-1:0] POINT_LAST = FW'(POINT_FRAMES - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic [3:0]    s1_q, s1_d;
  logic [3:0]    s2_q, s2_d;
  logic [1:0]    win_q, win_d;
  logic          dir_q, dir_d;
  logic          brst_q, brst_d;
  logic [2:0]    p1_sync_q, p1_sync_d;
  logic [2:0]    p2_sync_q, p2_sync_d;
  logic          p1_rise, p2_rise;
  logic          serve_entry;

  // Start pins: two sync stages, third stage remembers last level for edge detect.
  always_comb begin
    p1_sync_d = {p1_sync_q[1:0], p1_start};
    p2_sync_d = {p2_sync_q[1:0], p2_start};
    p1_rise   = p1_sync_q[1] & ~p1_sync_q[2];
    p2_rise   = p2_sync_q[1] & ~p2_sync_q[2];
  end

  // Game sequencing: next state, scores, serve direction and recentre pulse.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    win_d       = win_q;
    dir_d       = dir_q;
    brst_d      = 1'b0;
    serve_entry = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        if (p1_rise | p2_rise) begin
          state_d     = SERVE;
          cnt_d       = '0;
          s1_d        = '0;
          s2_d        = '0;
          win_d       = 2'b00;
          dir_d       = p1_rise;
          brst_d      = 1'b1;
          serve_entry = 1'b1;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PLAY: begin
        if (miss_left | miss_right) begin
          state_d = POINT;
          cnt_d   = '0;
          if (miss_left & ~miss_right) begin
            if (s2_q < WIN) s2_d = s2_q + 4'd1;
            dir_d = 1'b0;
          end else if (miss_right & ~miss_left) begin
            if (s1_q < WIN) s1_d = s1_q + 4'd1;
            dir_d = 1'b1;
          end
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            cnt_d = '0;
            if (s1_q == WIN || s2_q == WIN) begin
              state_d = OVER;
              win_d   = (s1_q == WIN) ? 2'b01 : 2'b10;
            end else begin
              state_d     = SERVE;
              brst_d      = 1'b1;
              serve_entry = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Game state registers.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      win_q     <= 2'b00;
      dir_q     <= 1'b0;
      brst_q    <= 1'b0;
      p1_sync_q <= '0;
      p2_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      win_q     <= win_d;
      dir_q     <= dir_d;
      brst_q    <= brst_d;
      p1_sync_q <= p1_sync_d;
      p2_sync_q <= p2_sync_d;
    end
  end

`ifdef PONG_SPEEDUP_EN
  localparam int HW = $clog2(HITS_PER_STEP + 1);
  localparam logic [HW-1:0] HIT_LAST = HW'(HITS_PER_STEP - 1);

  logic [HW-1:0] hit_q, hit_d;
  logic [2:0]    spd_q, spd_d;

  // Hit counter: every HITS_PER_STEP hits bump speed, saturating at 7.
  always_comb begin
    hit_d = hit_q;
    spd_d = spd_q;
    if (serve_entry) begin
      hit_d = '0;
      spd_d = 3'd1;
    end else if (state_q == PLAY && paddle_hit) begin
      if (hit_q == HIT_LAST) begin
        hit_d = '0;
        if (spd_q != 3'd7) spd_d = spd_q + 3'd1;
      end else begin
        hit_d = hit_q + 1'b1;
      end
    end
  end

  // Speed-up registers.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
      spd_q <= 3'd1;
    end else begin
      hit_q <= hit_d;
      spd_q <= spd_d;
    end
  end

  assign ball_speed = spd_q;
`else
  logic unused_sig;
  assign unused_sig = paddle_hit ^ serve_entry;
  assign ball_speed = 3'd1;
`endif

  assign ball_run   = (state_q == PLAY);
  assign ball_reset = brst_q;
  assign serve_dir  = dir_q;
  assign score_p1   = s1_q;
  assign score_p2   = s2_q;
  assign winner     = win_q;
  assign state      = state_q;
  assign led        = {s1_q, s2_q};

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed game scenarios checked against a rules-level model.
// Builds with or without PONG_SPEEDUP_EN.
`timescale 1ns/1ps
module tb_pong_game_ctrl;

  localparam int WIN = 7;
  localparam int SF  = 60;
  localparam int PF  = 90;
  localparam int HPS = 4;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       p1_start, p2_start;
  logic       miss_left, miss_right;
  logic       paddle_hit;
  logic       ball_run, ball_reset, serve_dir;
  logic [3:0] score_p1, score_p2;
  logic [1:0] winner;
  logic [2:0] state;
  logic [2:0] ball_speed;
  logic [7:0] led;

  int nvec = 0;
  int nmis = 0;

  pong_game_ctrl #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SF),
    .POINT_FRAMES(PF), .HITS_PER_STEP(HPS)
  ) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .p1_start(p1_start), .p2_start(p2_start),
    .miss_left(miss_left), .miss_right(miss_right),
    .paddle_hit(paddle_hit), .ball_run(ball_run),
    .ball_reset(ball_reset), .serve_dir(serve_dir),
    .score_p1(score_p1), .score_p2(score_p2),
    .winner(winner), .state(state),
    .ball_speed(ball_speed), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Rules model: game phase, scores, pin history queues.
  int m_st, m_s1, m_s2, m_win, m_dir, m_brst;
  int m_speed, m_hits, m_frames;
  int h1[$], h2[$];
  bit e1, e2, spd_en;

  initial begin
`ifdef PONG_SPEEDUP_EN
    spd_en = 1'b1;
`else
    spd_en = 1'b0;
`endif
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_st = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0;
        m_brst = 0; m_speed = 1; m_hits = 0; m_frames = 0;
        h1 = '{0, 0, 0};
        h2 = '{0, 0, 0};
      end else begin
        // A start press counts once seen two samples ago but not three.
        e1 = (h1[1] == 1) && (h1[2] == 0);
        e2 = (h2[1] == 1) && (h2[2] == 0);
        h1.push_front(int'(p1_start)); h1.delete(3);
        h2.push_front(int'(p2_start)); h2.delete(3);
        m_brst = 0;
        if (m_st == 2 && paddle_hit && spd_en) begin
          m_hits++;
          if (m_hits == HPS) begin
            m_hits = 0;
            if (m_speed < 7) m_speed++;
          end
        end
        case (m_st)
          0, 4: if (e1 || e2) begin
            m_s1 = 0; m_s2 = 0; m_win = 0;
            m_dir = e1 ? 1 : 0;
            m_st = 1; m_frames = 0; m_brst = 1;
            m_speed = 1; m_hits = 0;
          end
          1: if (frame_tick) begin
            m_frames++;
            if (m_frames == SF) begin m_st = 2; m_frames = 0; end
          end
          2: if (miss_left || miss_right) begin
            if (miss_left && !miss_right) begin
              m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1;
              m_dir = 0;
            end
            if (miss_right && !miss_left) begin
              m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
              m_dir = 1;
            end
            m_st = 3; m_frames = 0;
          end
          3: if (frame_tick) begin
            m_frames++;
            if (m_frames == PF) begin
              m_frames = 0;
              if (m_s1 == WIN) begin m_st = 4; m_win = 1; end
              else if (m_s2 == WIN) begin m_st = 4; m_win = 2; end
              else begin
                m_st = 1; m_brst = 1; m_speed = 1; m_hits = 0;
              end
            end
          end
          default: m_st = 0;
        endcase
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("state", int'(state), m_st);
    chk("ball_run", int'(ball_run), int'(m_st == 2));
    chk("ball_reset", int'(ball_reset), m_brst);
    chk("serve_dir", int'(serve_dir), m_dir);
    chk("score_p1", int'(score_p1), m_s1);
    chk("score_p2", int'(score_p2), m_s2);
    chk("winner", int'(winner), m_win);
    chk("ball_speed", int'(ball_speed), m_speed);
    chk("led", int'(led), m_s1 * 16 + m_s2);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step(1);
      frame_tick = 1'b0; step(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0;
    p1_start = 1'b0; p2_start = 1'b0;
    miss_left = 1'b0; miss_right = 1'b0; paddle_hit = 1'b0;
    step(3);
    chk("rst state", int'(state), 0);
    chk("rst led", int'(led), 0);
    chk("rst speed", int'(ball_speed), 1);
    rst_n = 1'b1;
    step(2);

    // P1 serve: recognised on the third edge after the pin rises.
    p1_start = 1'b1;
    step(2);
    chk("start lat2", int'(state), 0);
    step(1);
    chk("start lat3", int'(state), 1);
    chk("serve brst", int'(ball_reset), 1);
    chk("serve dir p1", int'(serve_dir), 1);
    p1_start = 1'b0;
    step(1);
    chk("brst one cyc", int'(ball_reset), 0);
    ticks(SF - 1);
    chk("serve hold", int'(state), 1);
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    chk("play state", int'(state), 2);
    chk("play run", int'(ball_run), 1);

    // P2 misses: point to P1, serve toward P2 after the point delay.
    miss_right = 1'b1; step(1); miss_right = 1'b0;
    chk("p1 point", int'(score_p1), 1);
    chk("point state", int'(state), 3);
    chk("point run", int'(ball_run), 0);
    ticks(PF - 1);
    chk("point hold", int'(state), 3);
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    chk("reserve", int'(state), 1);
    chk("reserve brst", int'(ball_reset), 1);
    chk("reserve dir", int'(serve_dir), 1);

    // Misses and hits during SERVE are ignored.
    miss_left = 1'b1; step(1); miss_left = 1'b0;
    miss_right = 1'b1; paddle_hit = 1'b1; step(1);
    miss_right = 1'b0; paddle_hit = 1'b0;
    chk("serve miss p2", int'(score_p2), 0);
    chk("serve miss p1", int'(score_p1), 1);
    chk("serve miss st", int'(state), 1);

    // Simultaneous misses: replay, nothing scored.
    ticks(SF);
    miss_left = 1'b1; miss_right = 1'b1; step(1);
    miss_left = 1'b0; miss_right = 1'b0;
    chk("dbl miss st", int'(state), 3);
    chk("dbl miss led", int'(led), 8'h10);
    chk("dbl miss dir", int'(serve_dir), 1);
    ticks(PF);

    // P2 runs the score up to the win.
    for (int k = 0; k < 6; k++) begin
      ticks(SF);
      miss_left = 1'b1; step(1); miss_left = 1'b0;
      ticks(PF);
    end
    chk("p2 six", int'(score_p2), 6);
    chk("p2 dir", int'(serve_dir), 0);
    ticks(SF);
    miss_left = 1'b1; step(1); miss_left = 1'b0;
    chk("p2 seven", int'(score_p2), 7);
    ticks(PF - 1);
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    chk("over state", int'(state), 4);
    chk("over winner", int'(winner), 2);
    chk("over led", int'(led), 8'h17);
    miss_right = 1'b1; step(1); miss_right = 1'b0;
    chk("over hold", int'(score_p1), 1);
    p2_start = 1'b1; step(3); p2_start = 1'b0;
    chk("restart st", int'(state), 1);
    chk("restart led", int'(led), 0);
    chk("restart win", int'(winner), 0);
    chk("restart dir", int'(serve_dir), 0);

    // Paddle hits in PLAY, start pins ignored mid-game.
    ticks(SF);
    for (int k = 0; k < 32; k++) begin
      paddle_hit = 1'b1; step(1); paddle_hit = 1'b0; step(1);
    end
`ifdef PONG_SPEEDUP_EN
    chk("speed sat", int'(ball_speed), 7);
`else
    chk("speed const", int'(ball_speed), 1);
`endif
    p2_start = 1'b1; step(4); p2_start = 1'b0;
    chk("start in play", int'(state), 2);
    miss_right = 1'b1; step(1); miss_right = 1'b0;
    ticks(PF);
    chk("speed reset", int'(ball_speed), 1);
    chk("serve again", int'(state), 1);

    // Asynchronous reset in the middle of a rally.
    ticks(SF);
    chk("pre rst play", int'(state), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async st", int'(state), 0);
    chk("async run", int'(ball_run), 0);
    chk("async led", int'(led), 0);
    chk("async dir", int'(serve_dir), 0);
    step(2);
    rst_n = 1'b1;

    // Both players press together: P1 side serves.
    p1_start = 1'b1; p2_start = 1'b1;
    step(2);
    chk("both lat2", int'(state), 0);
    step(1);
    chk("both st", int'(state), 1);
    chk("both dir", int'(serve_dir), 1);
    p1_start = 1'b0; p2_start = 1'b0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
